// File: rtl/custom_gate_bist.sv
// custom_gate_bist: built-in self test for the 3-input gate F = !C & (!A | B).
// Walks the eight {A,B,C} vectors in ascending order, allows SETTLE_CYCLES of
// settling per vector, then compares F against the internally computed golden
// value. Mismatches are counted (saturating at 15) and the first failing vector
// is captured.
// Optional feature macro: CUSTOM_GATE_BIST_LOOP_EN -- when defined, a run keeps
// wrapping from vector 7 back to vector 0 for as long as START is held high.
module custom_gate_bist #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       F,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [3:0] ERR_CNT,
    output logic       FAIL_VLD,
    output logic [2:0] FAIL_VEC
);

    localparam logic [3:0] SETTLE_L = SETTLE_CYCLES[3:0];

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t     state_q,    state_d;
    logic [2:0] vec_q,      vec_d;
    logic [3:0] settle_q,   settle_d;
    logic [3:0] err_q,      err_d;
    logic       fail_vld_q, fail_vld_d;
    logic [2:0] fail_vec_q, fail_vec_d;
    logic [2:0] abc_q,      abc_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic       pass_q,     pass_d;
    logic       mismatch_s;

    // Golden response of the gate for vector v = {A,B,C}.
    function automatic logic golden_f(input logic [2:0] v);
        return ~v[0] & (~v[2] | v[1]);
    endfunction

    // Error counter increment that sticks at 15.
    function automatic logic [3:0] sat_inc_f(input logic [3:0] x);
        logic [3:0] r;
        if (x == 4'd15) begin
            r = 4'd15;
        end else begin
            r = x + 4'd1;
        end
        return r;
    endfunction

    // Compare is always against the vector currently held on A/B/C.
    assign mismatch_s = (F != golden_f(abc_q));

    // State register and every registered output; RST clears all of it at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            vec_q      <= 3'd0;
            settle_q   <= 4'd0;
            err_q      <= 4'd0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= 3'd0;
            abc_q      <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
            abc_q      <= abc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    // Next-state logic: sequencing, result accumulation and the next values
    // of the status outputs (derived from the next state so they are registered).
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        settle_d   = settle_q;
        err_d      = err_q;
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;
        abc_d      = abc_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    // A fresh run: results cleared, vector 0 applied as DRIVE starts
                    // so A/B/C are stable for the whole DRIVE..CHECK window.
                    err_d      = 4'd0;
                    fail_vld_d = 1'b0;
                    fail_vec_d = 3'd0;
                    vec_d      = 3'd0;
                    abc_d      = 3'd0;
                    state_d    = ST_DRIVE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRIVE: begin
                settle_d = SETTLE_L;
                if (SETTLE_L == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                settle_d = settle_q - 4'd1;
                if (settle_q <= 4'd1) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    err_d = sat_inc_f(err_q);
                    if (!fail_vld_q) begin
                        fail_vld_d = 1'b1;
                        fail_vec_d = abc_q;
                    end else begin
                        fail_vld_d = fail_vld_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (vec_q != 3'd7) begin
                    vec_d   = vec_q + 3'd1;
                    abc_d   = vec_q + 3'd1;
                    state_d = ST_DRIVE;
                end else begin
`ifdef CUSTOM_GATE_BIST_LOOP_EN
                    if (START) begin
                        vec_d   = 3'd0;
                        abc_d   = 3'd0;
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    state_d = ST_DONE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                abc_d   = 3'd0;
            end
        endcase

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_d == 4'd0);
    end

    assign A        = abc_q[2];
    assign B        = abc_q[1];
    assign C        = abc_q[0];
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERR_CNT  = err_q;
    assign FAIL_VLD = fail_vld_q;
    assign FAIL_VEC = fail_vec_q;

    custom_gate_bist_chk u_chk (
        .CLK      (CLK),
        .RST      (RST),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PASS     (PASS),
        .ERR_CNT  (ERR_CNT),
        .FAIL_VLD (FAIL_VLD)
    );

endmodule

// custom_gate_bist_chk: invariants on the status outputs of custom_gate_bist.
module custom_gate_bist_chk (
    input logic       CLK,
    input logic       RST,
    input logic       BUSY,
    input logic       DONE,
    input logic       PASS,
    input logic [3:0] ERR_CNT,
    input logic       FAIL_VLD
);

    // A run is either in progress or finished, never both.
    a_busy_done_excl: assert property (@(posedge CLK) disable iff (RST) !(BUSY && DONE));

    // PASS is only meaningful alongside DONE.
    a_pass_needs_done: assert property (@(posedge CLK) disable iff (RST) PASS |-> DONE);

    // A first failure is recorded exactly when at least one mismatch was counted.
    a_fail_vld_cnt: assert property (@(posedge CLK) disable iff (RST) FAIL_VLD == (ERR_CNT != 4'd0));

endmodule

// File: tb/tb_custom_gate_bist.sv
// tb_custom_gate_bist: two BIST instances (SETTLE_CYCLES = 0 and 1) share
// clock, reset and START; each drives its own gate model. A cycle-time model
// predicts every status output from "edges since START was sampled".
module tb_custom_gate_bist;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    int         mode = 0;          // 0: golden ^ mask, 1: stuck at 0, 2: stuck at 1
    logic [7:0] mask = 8'h00;      // mismatching vectors the model expects
    logic       model_en = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    logic       a0, b0, c0, busy0, done0, pass0, fv0, f0;
    logic [3:0] err0;
    logic [2:0] fvec0;
    logic       a1, b1, c1, busy1, done1, pass1, fv1, f1;
    logic [3:0] err1;
    logic [2:0] fvec1;

    always #5 CLK = ~CLK;

    function automatic logic gold(input logic [2:0] v);
        return !v[0] && (!v[2] || v[1]);
    endfunction

    function automatic logic gate_f(input int md, input logic [7:0] mk, input logic [2:0] v);
        logic r;
        case (md)
            1:       r = 1'b0;
            2:       r = 1'b1;
            default: r = gold(v) ^ mk[v];
        endcase
        return r;
    endfunction

    assign f0 = gate_f(mode, mask, {a0, b0, c0});
    assign f1 = gate_f(mode, mask, {a1, b1, c1});

    custom_gate_bist #(.SETTLE_CYCLES(0)) dut0 (
        .CLK(CLK), .RST(RST), .START(START), .F(f0),
        .A(a0), .B(b0), .C(c0), .BUSY(busy0), .DONE(done0), .PASS(pass0),
        .ERR_CNT(err0), .FAIL_VLD(fv0), .FAIL_VEC(fvec0)
    );

    custom_gate_bist #(.SETTLE_CYCLES(1)) dut1 (
        .CLK(CLK), .RST(RST), .START(START), .F(f1),
        .A(a1), .B(b1), .C(c1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .ERR_CNT(err1), .FAIL_VLD(fv1), .FAIL_VEC(fvec1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int popcnt(input logic [7:0] m);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m[i]);
        return n;
    endfunction

    function automatic int lowbit(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    // Behavioural model: per instance, whether a run is active, how many
    // edges have passed since START was sampled (that edge = 1), whether a
    // result is held, and which vectors are expected to mismatch in this run.
    logic       run_q  [2];
    logic       res_q  [2];
    int         t_q    [2];
    logic [7:0] rmask_q[2];

    // Model update on each edge, cleared by reset like the DUT.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int d = 0; d < 2; d++) begin
                run_q[d] <= 1'b0;
                res_q[d] <= 1'b0;
                t_q[d]   <= 0;
                rmask_q[d] <= 8'h00;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (run_q[d]) begin
                    // 8 vectors of (S+2) cycles each, S = d
                    if (t_q[d] == 8 * (d + 2)) begin
                        run_q[d] <= 1'b0;
                        res_q[d] <= 1'b1;
                    end
                    t_q[d] <= t_q[d] + 1;
                end else if (START) begin
                    run_q[d]   <= 1'b1;
                    res_q[d]   <= 1'b0;
                    t_q[d]     <= 1;
                    rmask_q[d] <= mask;
                end
            end
        end
    end

    task automatic cmp_dut(input int d, input logic busy, input logic done, input logic pass,
                           input logic [3:0] err, input logic fv, input logic [2:0] fvec,
                           input logic [2:0] abc);
        int         k;
        int         e_err;
        logic [7:0] m;
        string      p;
        p = (d == 0) ? "s0" : "s1";
        if (run_q[d]) begin
            k = (t_q[d] - 1) / (d + 2);
            m = rmask_q[d] & ((8'd1 << k) - 8'd1);
            check({p, " busy"}, int'(busy), 1);
            check({p, " done"}, int'(done), 0);
            check({p, " pass"}, int'(pass), 0);
            check({p, " abc"}, int'(abc), k);
        end else if (res_q[d]) begin
            m = rmask_q[d];
            check({p, " busy"}, int'(busy), 0);
            check({p, " done"}, int'(done), 1);
            check({p, " pass"}, int'(pass), (m == 8'h00) ? 1 : 0);
        end else begin
            m = 8'h00;
            check({p, " busy"}, int'(busy), 0);
            check({p, " done"}, int'(done), 0);
            check({p, " pass"}, int'(pass), 0);
            check({p, " abc idle"}, int'(abc), 0);
        end
        e_err = popcnt(m);
        if (e_err > 15) e_err = 15;
        check({p, " err_cnt"}, int'(err), e_err);
        check({p, " fail_vld"}, int'(fv), (m != 8'h00) ? 1 : 0);
        check({p, " fail_vec"}, int'(fvec), lowbit(m));
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (model_en) begin
            cmp_dut(0, busy0, done0, pass0, err0, fv0, fvec0, {a0, b0, c0});
            cmp_dut(1, busy1, done1, pass1, err1, fv1, fvec1, {a1, b1, c1});
        end
    end

    // Pulse START for one edge and measure, counting that edge as 1, the edge
    // after which each instance shows DONE. Optionally re-pulse while busy.
    task automatic run_timed(input logic repulse, output int l0, output int l1);
        int n;
        l0 = 0;
        l1 = 0;
        n  = 0;
        @(negedge CLK);
        START = 1'b1;
        while ((l0 == 0 || l1 == 0) && n < 200) begin
            @(posedge CLK);
            n++;
            #1;
            if (n == 1) START = 1'b0;
            if (repulse && n == 4) START = 1'b1;
            if (repulse && n == 6) START = 1'b0;
            if (done0 && l0 == 0) l0 = n;
            if (done1 && l1 == 0) l1 = n;
        end
    endtask

    task automatic run_and_check_latency(input logic repulse);
        int l0, l1;
        run_timed(repulse, l0, l1);
        check("latency s0", l0, 17);
        check("latency s1", l1, 25);
    endtask

    initial begin
        int unsigned sel;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // good gate
        mode = 0; mask = 8'h00;
        run_and_check_latency(1'b0);
        check("good pass", int'(pass1), 1);
        check("good err", int'(err1), 0);
        check("good fvld", int'(fv1), 0);

        // stuck at 0: vectors 000, 010, 110 mismatch
        @(negedge CLK); mode = 1; mask = 8'h45;
        run_and_check_latency(1'b0);
        check("st0 err s1", int'(err1), 3);
        check("st0 fvld s1", int'(fv1), 1);
        check("st0 fvec s1", int'(fvec1), 0);
        check("st0 pass s1", int'(pass1), 0);
        check("st0 err s0", int'(err0), 3);

        // stuck at 1: vectors 001, 011, 100, 101, 111 mismatch; START re-pulsed while busy
        @(negedge CLK); mode = 2; mask = 8'hBA;
        run_and_check_latency(1'b1);
        check("st1 err s1", int'(err1), 5);
        check("st1 fvec s1", int'(fvec1), 1);
        check("st1 pass s1", int'(pass1), 0);
        check("st1 err s0", int'(err0), 5);
        check("st1 fvec s0", int'(fvec0), 1);

        // reset while s1 is in the WAIT cycle of vector 4 (edge 14)
        @(negedge CLK); mode = 0; mask = 8'h00;
        START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        repeat (13) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("rst abc s1", int'({a1, b1, c1}), 0);
        check("rst busy s1", int'(busy1), 0);
        check("rst done s0", int'(done0), 0);
        check("rst err s0", int'(err0), 0);
        check("rst fvld s0", int'(fv0), 0);
        check("rst fvec s0", int'(fvec0), 0);
        check("rst pass s0", int'(pass0), 0);
        @(negedge CLK); RST = 1'b0;
        repeat (3) @(negedge CLK);
        run_and_check_latency(1'b0);
        check("post-rst pass s1", int'(pass1), 1);

        // randomized gate faults, restarted straight from DONE
        for (int it = 0; it < 24; it++) begin
            @(negedge CLK);
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                mode = 1; mask = 8'h45;
            end else if (sel == 1) begin
                mode = 2; mask = 8'hBA;
            end else begin
                mode = 0; mask = 8'($urandom_range(0, 255));
            end
            run_and_check_latency(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

`ifdef CUSTOM_GATE_BIST_LOOP_EN
        // continuous mode: 3 mismatches per pass, START held over six passes
        begin
            int n;
            @(negedge CLK);
            model_en = 1'b0;
            mode = 1; mask = 8'h45;
            START = 1'b1;
            repeat (6 * 24) @(negedge CLK);
            check("loop busy s1", int'(busy1), 1);
            START = 1'b0;
            n = 0;
            while (!done1 && n < 100) begin
                @(negedge CLK);
                n++;
            end
            check("loop done s1", int'(done1), 1);
            check("loop err s1", int'(err1), 15);
            check("loop fvec s1", int'(fvec1), 0);
            check("loop fvld s1", int'(fv1), 1);
            check("loop pass s1", int'(pass1), 0);
        end
`endif

        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/custom_gate_bist.md
CUSTOM_GATE_BIST -- requirements
Module: custom_gate_bist

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of wait cycles between driving a vector and checking F (legal 0..15).
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port START  input  1  run request, sampled in IDLE or DONE.
REQ-005 SHALL have port F  input  1  output of the gate under test.
REQ-006 SHALL have ports A, B, C  output  1 each  registered stimulus driving the gate under test.
REQ-007 SHALL have port BUSY  output  1  high while a run is in progress.
REQ-008 SHALL have port DONE  output  1  high while in DONE state.
REQ-009 SHALL have port PASS  output  1  equals (ERR_CNT==0) while DONE is high, else 0.
REQ-010 SHALL have port ERR_CNT  output  4  count of mismatching vectors.
REQ-011 SHALL have port FAIL_VLD  output  1  set when the first mismatch is recorded.
REQ-012 SHALL have port FAIL_VEC  output  3  {A,B,C} of the first mismatching vector.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-014 IDLE: A/B/C=0, BUSY=0; START=1 -> clear ERR_CNT, FAIL_VLD, FAIL_VEC, vector counter=0; next state DRIVE.
REQ-015 DRIVE (1 cycle): {A,B,C} <= vector counter; load settle counter with SETTLE_CYCLES; next WAIT, or CHECK if SETTLE_CYCLES==0.
REQ-016 WAIT: decrement settle counter each cycle; go to CHECK after exactly SETTLE_CYCLES cycles.
REQ-017 CHECK (1 cycle): compare F against golden expected = !C & (!A | B), computed internally from the held vector.
REQ-018 On mismatch: ERR_CNT increments, saturating at 15; if FAIL_VLD==0, set FAIL_VLD=1 and FAIL_VEC=vector.
REQ-019 After CHECK: vector<7 -> increment vector, go DRIVE; vector==7 -> go DONE (loop rule in REQ-028).
REQ-020 A/B/C SHALL remain stable from DRIVE through CHECK of the same vector.
REQ-021 BUSY=1 in DRIVE, WAIT, CHECK; 0 in IDLE and DONE.
REQ-022 DONE: held until START=1, which restarts exactly as in REQ-014 (same cycle behaviour); ERR_CNT/FAIL_* hold their values in DONE.
REQ-023 START while BUSY SHALL be ignored.
REQ-024 Run latency: with SETTLE_CYCLES=S, DONE rises (8*(S+2))+1 rising edges after the edge sampling START (25 for S=1).

Reset
REQ-025 RST=1 SHALL immediately, without a clock, force state IDLE, A/B/C=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VLD=0, FAIL_VEC=0, internal counters=0.
REQ-026 Reset asserted mid-run SHALL abort the run; no result is retained; a new START is required after release.

Configuration
REQ-027 Macro CUSTOM_GATE_BIST_LOOP_EN SHALL select continuous mode.
REQ-028 Defined: after CHECK of vector 7, if START==1 then wrap vector to 0 and go DRIVE (ERR_CNT accumulates, saturating at 15; FAIL_* keep first failure), else go DONE; not defined: always go DONE after vector 7, START level ignored while BUSY.

Verification
REQ-029 Correct gate model, S=1, START pulse -> DONE at edge 25, PASS=1, ERR_CNT=0, FAIL_VLD=0.
REQ-030 F stuck at 0 -> ERR_CNT=3 (vectors 000,010,110), FAIL_VLD=1, FAIL_VEC=000, PASS=0.
REQ-031 F stuck at 1 -> ERR_CNT=5, FAIL_VEC=001, PASS=0; repeat with S=0 -> DONE at edge 17.
REQ-032 RST pulse during WAIT of vector 4 -> all outputs 0 asynchronously, state IDLE; fresh START completes normal run.
REQ-033 START re-pulsed while BUSY -> no effect on DONE timing; START in DONE -> counters cleared, new run.
REQ-034 With CUSTOM_GATE_BIST_LOOP_EN, F stuck at 0, START held for 6 passes -> ERR_CNT saturates at 15, DONE only after START drops and pass ends.
